// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/acknowledge port between the MEM-stage LSU (master) and
// the data memory (slave). Request fields are held stable while req is high.
interface mem_stage_lsu_if #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [XLEN/8-1:0]     be;
  logic [XLEN-1:0]       wdata;
  logic [XLEN-1:0]       rdata;
  logic                  ack;

  modport master (output req, we, addr, be, wdata, input rdata, ack);
  modport slave  (input req, we, addr, be, wdata, output rdata, ack);
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: load/store unit with wait-state tolerant req/ack memory port,
// fault detection (misaligned, illegal, timeout) and the MEM/WB pipeline register.
module mem_stage_lsu #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WAIT   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             ctrl_mem_read,
  input  logic             ctrl_mem_write,
  input  logic             ctrl_reg_write,
  input  logic             ctrl_mem_to_reg,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [4:0]       rd,
  output logic             stall_o,
  mem_stage_lsu_if.master  dmem,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic             wb_reg_write,
  output logic             wb_mem_to_reg,
  output logic [XLEN-1:0]  wb_alu_result,
  output logic [XLEN-1:0]  wb_mem_data,
  output logic [1:0]       wb_fault
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = $clog2(MAX_WAIT + 1);

  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic [1:0] {
    FAULT_NONE = 2'b00, FAULT_MISALIGN = 2'b01, FAULT_TIMEOUT = 2'b10, FAULT_ILLEGAL = 2'b11
  } fault_t;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_to_reg;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] mem_data;
    fault_t          fault;
  } wb_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  wb_t             wb_q, wb_d;
  logic            latch_req;

  // Request registers: the memory sees these, never the live EX/MEM inputs.
  logic            we_q, reg_write_q, mem_to_reg_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] alu_q, wdata_q;
  logic [NB-1:0]   be_q;

  logic            mem_op, illegal, misaligned, legal_f3;
  logic [3:0]      size_bytes;
  logic [7:0]      size_mask;
  logic [OFFW-1:0] off_in, align_mask;
  logic [NB-1:0]   be_in;
  logic [XLEN-1:0] wdata_in, lane, load_ext;

  assign mem_op     = in_valid & (ctrl_mem_read | ctrl_mem_write);
  assign off_in     = alu_result[OFFW-1:0];
  assign size_bytes = 4'd1 << funct3[1:0];
  assign align_mask = OFFW'(size_bytes - 4'd1);
  assign misaligned = |(off_in & align_mask);

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    legal_f3  = 1'b0;
    size_mask = 8'h01;
    wdata_in  = '0;
    if (ctrl_mem_read) begin
      unique case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_f3 = 1'b1;
        3'b011, 3'b110:                         legal_f3 = (XLEN == 64);
        default:                                legal_f3 = 1'b0;
      endcase
    end else if (ctrl_mem_write) begin
      unique case (funct3)
        3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
        3'b011:                 legal_f3 = (XLEN == 64);
        default:                legal_f3 = 1'b0;
      endcase
    end
    unique case (funct3[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
    // Store data is the low byte/half/word of rs2 repeated across every lane.
    for (int i = 0; i < NB; i++)
      wdata_in[8*i +: 8] = rs2_data[8*(i % int'(size_bytes)) +: 8];
  end

  assign illegal = (ctrl_mem_read & ctrl_mem_write) | ~legal_f3;
  assign be_in   = NB'(size_mask) << off_in;

  assign lane = dmem.rdata >> {alu_q[OFFW-1:0], 3'b000};

  always_comb begin
    load_ext = lane;
    unique case (funct3_q)
      3'b000:  load_ext = XLEN'($signed(lane[7:0]));
      3'b001:  load_ext = XLEN'($signed(lane[15:0]));
      3'b010:  load_ext = XLEN'($signed(lane[31:0]));
      3'b100:  load_ext = XLEN'(lane[7:0]);
      3'b101:  load_ext = XLEN'(lane[15:0]);
      3'b110:  load_ext = XLEN'(lane[31:0]);
      default: load_ext = lane;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch_req = 1'b0;
    stall_o   = 1'b0;
    wb_d      = '0;
    unique case (state_q)
      IDLE: begin
        wb_d.valid      = in_valid;
        wb_d.rd         = rd;
        wb_d.reg_write  = ctrl_reg_write;
        wb_d.mem_to_reg = ctrl_mem_to_reg;
        wb_d.alu        = alu_result;
        if (mem_op) begin
          if (illegal || misaligned) begin
            wb_d.reg_write = 1'b0;
            wb_d.fault     = illegal ? FAULT_ILLEGAL : FAULT_MISALIGN;
          end else begin
            latch_req  = 1'b1;
            stall_o    = 1'b1;
            wb_d.valid = 1'b0;
            cnt_d      = '0;
            state_d    = ACCESS;
          end
        end
      end
      ACCESS: begin
        wb_d.rd         = rd_q;
        wb_d.mem_to_reg = mem_to_reg_q;
        wb_d.alu        = alu_q;
        if (dmem.ack) begin
          wb_d.valid     = 1'b1;
          wb_d.reg_write = reg_write_q & ~we_q;
          wb_d.mem_data  = we_q ? '0 : load_ext;
          cnt_d          = '0;
          state_d        = IDLE;
        end else if (cnt_q == CW'(MAX_WAIT - 1)) begin
          wb_d.valid = 1'b1;
          wb_d.fault = FAULT_TIMEOUT;
          cnt_d      = '0;
          state_d    = IDLE;
        end else begin
          stall_o = 1'b1;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wb_q         <= '0;
      we_q         <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      funct3_q     <= '0;
      rd_q         <= '0;
      alu_q        <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_q    <= wb_d;
      if (latch_req) begin
        we_q         <= ctrl_mem_write;
        reg_write_q  <= ctrl_reg_write;
        mem_to_reg_q <= ctrl_mem_to_reg;
        funct3_q     <= funct3;
        rd_q         <= rd;
        alu_q        <= alu_result;
        wdata_q      <= ctrl_mem_write ? wdata_in : '0;
        be_q         <= ctrl_mem_write ? be_in : '0;
      end
    end
  end

  assign dmem.req   = (state_q == ACCESS);
  assign dmem.we    = we_q;
  assign dmem.addr  = alu_q[ADDR_WIDTH-1:0];
  assign dmem.be    = be_q;
  assign dmem.wdata = wdata_q;

  assign wb_valid      = wb_q.valid;
  assign wb_rd         = wb_q.rd;
  assign wb_reg_write  = wb_q.reg_write;
  assign wb_mem_to_reg = wb_q.mem_to_reg;
  assign wb_alu_result = wb_q.alu;
  assign wb_mem_data   = wb_q.mem_data;
  assign wb_fault      = wb_q.fault;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu (XLEN=32, MAX_WAIT=16): ALU pass-through, loads,
// stores, faults, wait states, timeout, stray ack and reset during an access.
module tb_mem_stage_lsu;
  localparam int XLEN = 32;
  localparam int AW   = 32;
  localparam int MW   = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 0, mem_read = 0, mem_write = 0, reg_write = 0, mem_to_reg = 0;
  logic [2:0]      funct3 = '0;
  logic [XLEN-1:0] alu_result = '0, rs2_data = '0;
  logic [4:0]      rd = '0;
  logic            stall;
  logic            wb_valid, wb_reg_write, wb_mem_to_reg;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_alu_result, wb_mem_data;
  logic [1:0]      wb_fault;

  int passed = 0;
  int total  = 0;

  mem_stage_lsu_if #(.XLEN(XLEN), .ADDR_WIDTH(AW)) dmem ();

  mem_stage_lsu #(.XLEN(XLEN), .ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .ctrl_mem_read(mem_read), .ctrl_mem_write(mem_write),
    .ctrl_reg_write(reg_write), .ctrl_mem_to_reg(mem_to_reg),
    .funct3(funct3), .alu_result(alu_result), .rs2_data(rs2_data), .rd(rd),
    .stall_o(stall), .dmem(dmem.master),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_alu_result(wb_alu_result),
    .wb_mem_data(wb_mem_data), .wb_fault(wb_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic r, input logic w, input logic rw,
                       input logic m2r, input logic [2:0] f3, input logic [XLEN-1:0] alu,
                       input logic [XLEN-1:0] rs2, input logic [4:0] dst);
    in_valid = v; mem_read = r; mem_write = w; reg_write = rw; mem_to_reg = m2r;
    funct3 = f3; alu_result = alu; rs2_data = rs2; rd = dst;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 3'b000, '0, '0, '0);
  endtask

  initial begin
    dmem.ack   = 1'b0;
    dmem.rdata = '0;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_req", dmem.req, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_fault", wb_fault, 2'b00);
    rst_n = 1'b1;
    tick();

    // ALU op: one-cycle pass-through, no stall
    drive(1, 0, 0, 1, 0, 3'b000, 32'h1234_5678, '0, 5'd5);
    #1;
    check("alu_stall", stall, 1'b0);
    check("alu_req", dmem.req, 1'b0);
    tick();
    idle();
    check("alu_wb_valid", wb_valid, 1'b1);
    check("alu_wb_rd", wb_rd, 5'd5);
    check("alu_wb_result", wb_alu_result, 32'h1234_5678);
    check("alu_wb_reg_write", wb_reg_write, 1'b1);

    // LB 0x103, ack in first ACCESS cycle
    drive(1, 1, 0, 1, 1, 3'b000, 32'h103, '0, 5'd7);
    #1;
    check("lb_stall_idle", stall, 1'b1);
    check("lb_req_idle", dmem.req, 1'b0);
    tick();
    check("lb_req", dmem.req, 1'b1);
    check("lb_addr", dmem.addr, 32'h103);
    check("lb_we", dmem.we, 1'b0);
    check("lb_wb_bubble", wb_valid, 1'b0);
    dmem.ack = 1'b1; dmem.rdata = 32'h80FF_1234;
    #1;
    check("lb_stall_ack", stall, 1'b0);
    tick();
    dmem.ack = 1'b0; idle();
    check("lb_wb_valid", wb_valid, 1'b1);
    check("lb_mem_data", wb_mem_data, 32'hFFFF_FF80);
    check("lb_fault", wb_fault, 2'b00);
    check("lb_wb_rd", wb_rd, 5'd7);
    check("lb_reg_write", wb_reg_write, 1'b1);
    check("lb_mem_to_reg", wb_mem_to_reg, 1'b1);
    check("lb_alu", wb_alu_result, 32'h103);
    check("lb_req_done", dmem.req, 1'b0);

    // SH 0x102
    drive(1, 0, 1, 1, 0, 3'b001, 32'h102, 32'hABCD_5678, 5'd9);
    #1;
    check("sh_stall", stall, 1'b1);
    tick();
    check("sh_req", dmem.req, 1'b1);
    check("sh_we", dmem.we, 1'b1);
    check("sh_be", dmem.be, 4'b1100);
    check("sh_wdata", dmem.wdata, 32'h5678_5678);
    dmem.ack = 1'b1;
    tick();
    dmem.ack = 1'b0; idle();
    check("sh_wb_valid", wb_valid, 1'b1);
    check("sh_reg_write", wb_reg_write, 1'b0);
    check("sh_fault", wb_fault, 2'b00);

    // SB 0x101: single lane, byte replicated
    drive(1, 0, 1, 0, 0, 3'b000, 32'h101, 32'h1122_33C4, 5'd0);
    tick();
    check("sb_be", dmem.be, 4'b0010);
    check("sb_wdata", dmem.wdata, 32'hC4C4_C4C4);
    dmem.ack = 1'b1;
    tick();
    dmem.ack = 1'b0; idle();

    // LW 0x101: misaligned, no request
    drive(1, 1, 0, 1, 1, 3'b010, 32'h101, '0, 5'd3);
    #1;
    check("lw_mis_stall", stall, 1'b0);
    tick();
    idle();
    check("lw_mis_req", dmem.req, 1'b0);
    check("lw_mis_valid", wb_valid, 1'b1);
    check("lw_mis_fault", wb_fault, 2'b01);
    check("lw_mis_reg_write", wb_reg_write, 1'b0);

    // funct3=011 load on XLEN=32, also misaligned: illegal wins
    drive(1, 1, 0, 1, 1, 3'b011, 32'h101, '0, 5'd3);
    #1;
    check("ill_stall", stall, 1'b0);
    tick();
    idle();
    check("ill_fault", wb_fault, 2'b11);
    check("ill_req", dmem.req, 1'b0);

    // Read and write both set: illegal
    drive(1, 1, 1, 1, 0, 3'b000, 32'h100, '0, 5'd3);
    tick();
    idle();
    check("rw_fault", wb_fault, 2'b11);
    check("rw_reg_write", wb_reg_write, 1'b0);

    // LHU 0x0, ack withheld 3 cycles -> stall high 4 cycles
    drive(1, 1, 0, 1, 1, 3'b101, 32'h0, '0, 5'd12);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("lhu_stall_%0d", i), stall, 1'b1);
      tick();
    end
    dmem.ack = 1'b1; dmem.rdata = 32'hAAAA_8001;
    #1;
    check("lhu_stall_ack", stall, 1'b0);
    tick();
    dmem.ack = 1'b0; idle();
    check("lhu_mem_data", wb_mem_data, 32'h0000_8001);
    check("lhu_valid", wb_valid, 1'b1);
    check("lhu_rd", wb_rd, 5'd12);

    // LH 0x2: upper half, sign-extended
    drive(1, 1, 0, 1, 1, 3'b001, 32'h2, '0, 5'd13);
    tick();
    dmem.ack = 1'b1; dmem.rdata = 32'h9ABC_0000;
    tick();
    dmem.ack = 1'b0; idle();
    check("lh_mem_data", wb_mem_data, 32'hFFFF_9ABC);

    // LW 0x200, never acked -> timeout
    drive(1, 1, 0, 1, 1, 3'b010, 32'h200, '0, 5'd20);
    #1;
    check("to_stall_idle", stall, 1'b1);
    tick();
    for (int i = 0; i < MW - 1; i++) begin
      check($sformatf("to_stall_%0d", i), stall, 1'b1);
      tick();
    end
    check("to_stall_last", stall, 1'b0);
    check("to_req_last", dmem.req, 1'b1);
    tick();
    idle();
    check("to_fault", wb_fault, 2'b10);
    check("to_valid", wb_valid, 1'b1);
    check("to_reg_write", wb_reg_write, 1'b0);
    check("to_req_idle", dmem.req, 1'b0);

    // Late ack after timeout is ignored
    dmem.ack = 1'b1; dmem.rdata = 32'hDEAD_BEEF;
    #1;
    check("stray_stall", stall, 1'b0);
    tick();
    dmem.ack = 1'b0;
    check("stray_valid", wb_valid, 1'b0);
    check("stray_fault", wb_fault, 2'b00);
    check("stray_req", dmem.req, 1'b0);

    // Reset asserted mid-ACCESS
    drive(1, 1, 0, 1, 1, 3'b010, 32'h300, '0, 5'd21);
    tick();
    check("rst_mid_req_before", dmem.req, 1'b1);
    #2;
    rst_n = 1'b0;
    idle();
    #1;
    check("rst_mid_req_drop", dmem.req, 1'b0);
    check("rst_mid_stall", stall, 1'b0);
    #3;
    rst_n = 1'b1;
    tick();
    check("rst_mid_wb_valid", wb_valid, 1'b0);
    check("rst_mid_req_after", dmem.req, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
